// File: rtl/quota_pkg.sv
// Shared types and helpers for the multi-channel quota stream generator.
// Quota width and rounding shift are derived from QUANT and BITSTREAM.
package quota_pkg;

  localparam int DEF_CH        = 4;
  localparam int DEF_QUANT     = 8;
  localparam int DEF_BITSTREAM = 64;

  typedef enum logic {IDLE, STREAM} state_e;
  typedef enum logic {THERMO, BITREV} mode_e;

  function automatic int lb_of(input int bitstream);
    return $clog2(bitstream);
  endfunction

  function automatic int sh_of(input int quant, input int bitstream);
    return quant - $clog2(bitstream);
  endfunction

  // Reverses the low 'width' bits of value; higher result bits stay zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[width-1-i] = value[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/quota_calc.sv
// Converts one signed sample to a rounded quota in 0..BITSTREAM.
// The offset-binary bias keeps full scale reachable without wrapping to zero.
module quota_calc
  import quota_pkg::*;
#(
  parameter int QUANT     = DEF_QUANT,
  parameter int BITSTREAM = DEF_BITSTREAM
) (
  input  logic [QUANT-1:0]           data_i,
  output logic [$clog2(BITSTREAM):0] quota_o
);

  localparam int SH = sh_of(QUANT, BITSTREAM);

  logic [QUANT:0] bias;

  // Flipping the sign bit adds 2^(QUANT-1) to a two's complement value.
  assign bias = {1'b0, data_i ^ (QUANT'(1) << (QUANT - 1))};

  if (SH > 0) begin : g_round
    logic [QUANT:0] rounded;
    assign rounded = bias + (QUANT + 1)'(1 << (SH - 1));
    assign quota_o = rounded[QUANT:SH];
  end else begin : g_exact
    assign quota_o = bias;
  end

endmodule

// File: rtl/quota_stream_gen.sv
// Multi-channel quota stream generator: latches CH quotas and emits a BITSTREAM-beat
// stochastic bitstream per channel, in thermometer or bit-reversed order.
module quota_stream_gen
  import quota_pkg::*;
#(
  parameter int CH        = DEF_CH,
  parameter int QUANT     = DEF_QUANT,
  parameter int BITSTREAM = DEF_BITSTREAM
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [CH*QUANT-1:0]                   in_data,
  input  logic                                  in_mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CH-1:0]                         out_bits,
  output logic                                  out_last,
  output logic [CH*($clog2(BITSTREAM)+1)-1:0]   out_quota
);

  localparam int LB = lb_of(BITSTREAM);

  if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_bitstream
    $error("quota_stream_gen: BITSTREAM must be a power of two >= 2");
  end
  if (QUANT < LB) begin : g_bad_quant
    $error("quota_stream_gen: QUANT must be >= clog2(BITSTREAM)");
  end

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [LB-1:0] cnt_q, cnt_d;
  logic [LB:0]   quota_q [CH];
  logic [LB:0]   quota_d [CH];
  logic [LB:0]   calc_w  [CH];
  logic [LB:0]   idx;

  for (genvar c = 0; c < CH; c++) begin : g_calc
    quota_calc #(
      .QUANT    (QUANT),
      .BITSTREAM(BITSTREAM)
    ) u_quota_calc (
      .data_i (in_data[c*QUANT +: QUANT]),
      .quota_o(calc_w[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= THERMO;
      cnt_q   <= '0;
      for (int c = 0; c < CH; c++) quota_q[c] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      for (int c = 0; c < CH; c++) quota_q[c] <= quota_d[c];
    end
  end

  // A final-beat handshake may coincide with accepting the next vector.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    for (int c = 0; c < CH; c++) quota_d[c] = quota_q[c];
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = STREAM;
          mode_d  = mode_e'(in_mode);
          cnt_d   = '0;
          for (int c = 0; c < CH; c++) quota_d[c] = calc_w[c];
        end
      end
      STREAM: begin
        if (out_valid && out_ready) begin
          cnt_d = cnt_q + LB'(1);
          if (out_last) begin
            if (in_valid && in_ready) begin
              mode_d = mode_e'(in_mode);
              for (int c = 0; c < CH; c++) quota_d[c] = calc_w[c];
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == STREAM);
    out_last  = out_valid && (cnt_q == LB'(BITSTREAM - 1));
    in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);
    if (mode_q == BITREV) idx = (LB + 1)'(bitrev(32'(cnt_q), LB));
    else                  idx = {1'b0, cnt_q};
    out_bits  = '0;
    out_quota = '0;
    for (int c = 0; c < CH; c++) begin
      out_bits[c]                    = out_valid && (idx < quota_q[c]);
      out_quota[c*(LB+1) +: (LB+1)]  = quota_q[c];
    end
  end

endmodule

// File: tb/tb_quota_stream_gen.sv
// Self-checking bench for quota_stream_gen: a beat-level reference model compared every
// cycle, plus literal expectations for quotas, popcounts, latency and reset behaviour.
module tb_quota_stream_gen;

  localparam int CH        = 4;
  localparam int QUANT     = 8;
  localparam int BITSTREAM = 64;
  localparam int LB        = 6;
  localparam int SH        = QUANT - LB;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CH*QUANT-1:0]  in_data = '0;
  logic                 in_mode = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [CH-1:0]        out_bits;
  logic                 out_last;
  logic [CH*(LB+1)-1:0] out_quota;

  int  total = 0;
  int  bad   = 0;
  bit  stallEn = 1'b0;

  // Reference model state: whether a stream is running, which beat, and its quotas.
  bit  mActive;
  int  mBeat;
  bit  mMode;
  int  mQ [CH];

  int  pop [CH];
  int  beats;
  int  lastPop [CH];
  int  lastLen;
  logic [CH-1:0] lastBits;
  bit  prevStall;
  logic [CH-1:0] prevBits;
  logic prevLast;

  quota_stream_gen #(
    .CH       (CH),
    .QUANT    (QUANT),
    .BITSTREAM(BITSTREAM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bits (out_bits),
    .out_last (out_last),
    .out_quota(out_quota)
  );

  always #5 clk = ~clk;

  function automatic int quotaOf(input logic [QUANT-1:0] d);
    int v;
    v = int'($signed(d));
    return (v + (1 << (QUANT - 1)) + (1 << (SH - 1))) >> SH;
  endfunction

  function automatic int revBeat(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LB; i++) if (v & (1 << i)) r |= 1 << (LB - 1 - i);
    return r;
  endfunction

  function automatic logic [CH-1:0] modelBits();
    logic [CH-1:0] b;
    int idx;
    b = '0;
    idx = mMode ? revBeat(mBeat) : mBeat;
    for (int c = 0; c < CH; c++) b[c] = mActive && (idx < mQ[c]);
    return b;
  endfunction

  function automatic logic [CH*(LB+1)-1:0] modelQuota();
    logic [CH*(LB+1)-1:0] q;
    q = '0;
    for (int c = 0; c < CH; c++) q[c*(LB+1) +: (LB+1)] = (LB + 1)'(mQ[c]);
    return q;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edges as the DUT, using only bench-driven inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive <= 1'b0;
      mBeat   <= 0;
      mMode   <= 1'b0;
      for (int c = 0; c < CH; c++) mQ[c] <= 0;
    end else if (mActive && out_ready && mBeat == BITSTREAM - 1) begin
      mBeat <= 0;
      if (in_valid) begin
        mMode <= in_mode;
        for (int c = 0; c < CH; c++) mQ[c] <= quotaOf(in_data[c*QUANT +: QUANT]);
      end else begin
        mActive <= 1'b0;
      end
    end else if (mActive && out_ready) begin
      mBeat <= mBeat + 1;
    end else if (!mActive && in_valid) begin
      mActive <= 1'b1;
      mBeat   <= 0;
      mMode   <= in_mode;
      for (int c = 0; c < CH; c++) mQ[c] <= quotaOf(in_data[c*QUANT +: QUANT]);
    end
  end

  // Compare process: every falling edge while out of reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) pop[c] = 0;
      beats = 0;
      prevStall = 1'b0;
    end else begin
      checkOutput("out_valid", out_valid, mActive);
      checkOutput("out_last", out_last, mActive && mBeat == BITSTREAM - 1);
      checkOutput("in_ready", in_ready, !mActive || (out_ready && mBeat == BITSTREAM - 1));
      checkOutput("out_bits", out_bits, modelBits());
      checkOutput("out_quota", out_quota, modelQuota());
      if (prevStall) begin
        checkOutput("stall_bits", out_bits, prevBits);
        checkOutput("stall_last", out_last, prevLast);
      end
      prevStall = mActive && !out_ready;
      prevBits  = out_bits;
      prevLast  = out_last;
      if (mActive && out_ready) begin
        for (int c = 0; c < CH; c++) pop[c] += int'(out_bits[c]);
        beats++;
        if (mBeat == BITSTREAM - 1) begin
          for (int c = 0; c < CH; c++) begin
            checkOutput("popcount", pop[c], mQ[c]);
            lastPop[c] = pop[c];
            pop[c] = 0;
          end
          lastLen  = beats;
          lastBits = out_bits;
          beats    = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = stallEn ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic applyStimulus(input logic [CH*QUANT-1:0] data, input logic mode, input bit hold);
    bit accepted;
    bit rdy;
    accepted = 1'b0;
    in_data  = data;
    in_mode  = mode;
    in_valid = 1'b1;
    for (int n = 0; n < 300 && !accepted; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      accepted = rdy;
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid && n < limit);
    if (n >= limit) checkOutput("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_bits", out_bits, 0);
    checkOutput("rst_out_quota", out_quota, 0);

    // Test 1: {0,-128,127,-126} in thermometer order.
    applyStimulus({8'h82, 8'h7F, 8'h80, 8'h00}, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_quota", out_quota, {7'd1, 7'd64, 7'd0, 7'd32});
    checkOutput("t1_beat0", out_bits, 4'b1101);
    waitIdle(200);
    checkOutput("t1_pop0", lastPop[0], 32);
    checkOutput("t1_pop1", lastPop[1], 0);
    checkOutput("t1_pop2", lastPop[2], 64);
    checkOutput("t1_pop3", lastPop[3], 1);
    checkOutput("t1_len", lastLen, 64);

    // Test 2: zero data, bit-reversed order alternates 1,0.
    applyStimulus('0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t2_beat0", out_bits, 4'hF);
    @(negedge clk);
    checkOutput("t2_beat1", out_bits, 4'h0);
    waitIdle(200);
    checkOutput("t2_pop", lastPop[2], 32);

    // Test 3: random backpressure in both orders.
    stallEn = 1'b1;
    applyStimulus({8'h10, 8'hF0, 8'h55, 8'hAA}, 1'b1, 1'b0);
    waitIdle(2000);
    applyStimulus({8'h3C, 8'hC3, 8'h01, 8'hFE}, 1'b0, 1'b0);
    waitIdle(2000);
    stallEn = 1'b0;
    @(posedge clk);
    #2;

    // Test 4: in_valid held high; second vector taken on the last beat, no bubble.
    applyStimulus({8'h20, 8'hE0, 8'h40, 8'hC0}, 1'b0, 1'b1);
    in_data = {8'h7F, 8'h81, 8'h00, 8'h11};
    in_mode = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    checkOutput("t4_ready_at_beat63", n, 64);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_no_gap_valid", out_valid, 1);
    checkOutput("t4_no_gap_last", out_last, 0);
    waitIdle(200);
    checkOutput("t4_len", lastLen, 64);

    // Test 5: reset mid-stream at beat 20.
    applyStimulus({8'h7F, 8'h7F, 8'h7F, 8'h7F}, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_valid_in_rst", out_valid, 0);
    checkOutput("t5_bits_in_rst", out_bits, 0);
    checkOutput("t5_last_in_rst", out_last, 0);
    checkOutput("t5_quota_in_rst", out_quota, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_ready_after", in_ready, 1);
    applyStimulus({8'h00, 8'h40, 8'hC0, 8'h7F}, 1'b0, 1'b0);
    waitIdle(200);
    checkOutput("t5_len", lastLen, 64);

    // Test 6: -127 -> 0 and 125 -> 63 (last beat stays zero).
    applyStimulus({8'h80, 8'h00, 8'h7D, 8'h81}, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_quota", out_quota, {7'd0, 7'd32, 7'd63, 7'd0});
    waitIdle(200);
    checkOutput("t6_pop0", lastPop[0], 0);
    checkOutput("t6_pop1", lastPop[1], 63);
    checkOutput("t6_last_bit1", lastBits[1], 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
